// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch sequencer in front of a 16-bit instruction register that is loaded
//   one byte at a time (8-bit data, LH byte select, Write strobe). On each
//   request it reads PC (low byte) and PC+1 (high byte) from a byte-wide
//   memory and presents every byte to the IR with a one-cycle write pulse.
//   It owns the program counter, accepts branch loads and flags timeouts.
//
// Handshake: the memory side is a request/valid pair. mem_read_o is held
//   high with a stable mem_address_o until the fetch unit samples
//   mem_valid_i=1 on a rising edge. That edge consumes mem_data_i. The
//   fetch unit ignores mem_valid_i whenever mem_read_o is low.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   fetch_req_i          request the next instruction (sampled in IDLE)
//   pc_load_i            load PC from pc_load_value_i (IDLE / ERR only)
//   pc_load_value_i      branch target
//   mem_address_o        byte address (= PC)
//   mem_read_o           read strobe, high while waiting for a byte
//   mem_data_i           read data
//   mem_valid_i          read data valid
//   ir_data_o            byte driven to the IR
//   ir_lh_o              0 = low byte, 1 = high byte
//   ir_write_o           one-cycle IR write pulse per byte
//   fetch_done_o         one-cycle pulse: IR holds the complete new word
//   busy_o               high while a fetch is in progress
//   fetch_error_o        sticky memory-timeout flag
//   pc_o                 current PC
//   state_o              FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int ADDR_W         = 16,
  parameter int RESET_PC       = 0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_req_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_load_value_i,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_o,
  input  logic [7:0]        mem_data_i,
  input  logic              mem_valid_i,
  output logic [7:0]        ir_data_o,
  output logic              ir_lh_o,
  output logic              ir_write_o,
  output logic              fetch_done_o,
  output logic              busy_o,
  output logic              fetch_error_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_LO = 3'd1,
    S_REQ_HI = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  // Counter only has to reach TIMEOUT_CYCLES-1; a zero timeout disables it.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [7:0]        ir_data_q, ir_data_d;
  logic              ir_lh_q, ir_lh_d;
  logic              ir_write_q, ir_write_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      wait_q     <= '0;
      ir_data_q  <= '0;
      ir_lh_q    <= 1'b0;
      ir_write_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_q     <= wait_d;
      ir_data_q  <= ir_data_d;
      ir_lh_q    <= ir_lh_d;
      ir_write_q <= ir_write_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_d     = wait_q;
    ir_data_d  = ir_data_q;
    ir_lh_d    = ir_lh_q;
    ir_write_d = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        // A load and a request in the same cycle fetch from the new target.
        if (pc_load_i) pc_d = pc_load_value_i;
        if (fetch_req_i) begin
          state_d = S_REQ_LO;
          wait_d  = '0;
        end
      end

      S_REQ_LO, S_REQ_HI: begin
        if (mem_valid_i) begin
          ir_data_d  = mem_data_i;
          ir_lh_d    = (state_q == S_REQ_HI);
          ir_write_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          wait_d     = '0;
          state_d    = (state_q == S_REQ_HI) ? S_DONE : S_REQ_HI;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          // PC is left pointing at the byte that never arrived.
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // The high-byte write is on the IR this cycle; the word is complete
        // once this edge passes, so FetchDone lands in the next IDLE cycle.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        if (pc_load_i) begin
          pc_d    = pc_load_value_i;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_address_o = pc_q;
  assign mem_read_o    = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);
  assign busy_o        = mem_read_o || (state_q == S_DONE);
  assign ir_data_o     = ir_data_q;
  assign ir_lh_o       = ir_lh_q;
  assign ir_write_o    = ir_write_q;
  assign fetch_done_o  = done_q;
  assign fetch_error_o = err_q;
  assign pc_o          = pc_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = '0;
  logic [15:0] mem_address;
  logic        mem_read;
  logic [7:0]  mem_data = '0;
  logic        mem_valid = 1'b0;
  logic [7:0]  ir_data;
  logic        ir_lh;
  logic        ir_write;
  logic        fetch_done;
  logic        busy;
  logic        fetch_error;
  logic [15:0] pc_out;
  logic [2:0]  dbg_state;

  instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(0), .TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_req_i(fetch_req), .pc_load_i(pc_load), .pc_load_value_i(pc_load_value),
    .mem_address_o(mem_address), .mem_read_o(mem_read),
    .mem_data_i(mem_data), .mem_valid_i(mem_valid),
    .ir_data_o(ir_data), .ir_lh_o(ir_lh), .ir_write_o(ir_write),
    .fetch_done_o(fetch_done), .busy_o(busy), .fetch_error_o(fetch_error),
    .pc_o(pc_out), .state_o(dbg_state)
  );

  // ---------------- reference model state ----------------
  logic [7:0]  mem [65536];
  logic [15:0] pc_m = '0;
  logic [8:0]  exp_q[$];       // {lh, byte} expected on each IR write
  logic [31:0] done_q[$];      // {pc after fetch, IR word}
  int          done_cycles[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  int  min_delay = 0;
  int  max_delay = 0;
  bit  hang = 1'b0;
  int  wait_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  always @(negedge clk) begin
    if (!rst_n || !mem_read) begin
      // Noise on the valid line while no read is outstanding must be ignored.
      mem_valid = 1'($urandom_range(1, 0));
      mem_data  = 8'($urandom);
      wait_left = $urandom_range(max_delay, min_delay);
    end else if (hang) begin
      mem_valid = 1'b0;
    end else if (wait_left == 0) begin
      mem_valid = 1'b1;
      mem_data  = mem[mem_address];
      wait_left = $urandom_range(max_delay, min_delay);
    end else begin
      mem_valid = 1'b0;
      mem_data  = 8'($urandom);
      wait_left--;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_read = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_addr = '0;
  logic        prev_wr = 1'b0;
  logic        prev_lh = 1'b0;
  logic [15:0] ir_model = '0;

  always @(posedge clk) begin
    cyc++;
    prev_read  = mem_read && rst_n;
    prev_valid = mem_valid;
    prev_addr  = mem_address;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read && prev_read && !prev_valid)
        check("addr_stable", {16'h0, mem_address}, {16'h0, prev_addr});
      if (ir_write) begin
        if (prev_wr) check("irwrite_lh_order", {31'h0, ir_lh}, {31'h0, ~prev_lh});
        if (exp_q.size() == 0) begin
          check("unexpected_irwrite", {23'h0, ir_lh, ir_data}, 32'h1ff);
        end else begin
          check("irwrite_byte", {23'h0, ir_lh, ir_data}, {23'h0, exp_q.pop_front()});
        end
        if (ir_lh) ir_model[15:8] = ir_data;
        else       ir_model[7:0]  = ir_data;
      end
      if (fetch_done) begin
        done_cycles.push_back(cyc);
        if (done_q.size() == 0) check("unexpected_done", {pc_out, ir_model}, 32'hffffffff);
        else check("fetch_done_pc_ir", {pc_out, ir_model}, done_q.pop_front());
      end
      prev_wr = ir_write;
      prev_lh = ir_lh;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered just after a rising edge or at a falling edge.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || fetch_error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic issue(input bit load, input logic [15:0] val, input bit hold, input bit expect_data);
    wait_idle();
    fetch_req     = 1'b1;
    pc_load       = load;
    pc_load_value = val;
    if (load) pc_m = val;
    if (expect_data) begin
      exp_q.push_back({1'b0, mem[pc_m]});
      exp_q.push_back({1'b1, mem[pc_m + 16'd1]});
      done_q.push_back({pc_m + 16'd2, mem[pc_m + 16'd1], mem[pc_m]});
      pc_m = pc_m + 16'd2;
    end
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    if (!hold) fetch_req = 1'b0;
  endtask

  // Counts falling edges from the accepting edge up to the FetchDone cycle.
  task automatic wait_done(input int exp_lat, input int already);
    int n = already;
    do begin
      @(negedge clk);
      n++;
    end while (!fetch_done && n < 200);
    if (!fetch_done) check("done_wait_expired", 32'd1, 32'd0);
    else if (exp_lat > 0) check("done_latency", n, exp_lat);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("queues_drained", exp_q.size() + done_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] start_pc;
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34;
    mem[1] = 8'h12;

    // Reset values
    #2;
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    check("rst_outs", {ir_data, ir_lh, ir_write, fetch_done, fetch_error, mem_read, busy},
          13'h0);
    check("rst_pc", {16'h0, pc_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. zero-wait fetch from 0
    min_delay = 0; max_delay = 0;
    issue(1'b0, 16'h0, 1'b0, 1'b1);
    wait_done(4, 0);
    check("t1_pc", {16'h0, pc_out}, 32'h0002);
    check("t1_ir", {16'h0, ir_model}, 32'h1234);

    // 2. three wait cycles per byte
    min_delay = 3; max_delay = 3;
    issue(1'b1, 16'h0, 1'b0, 1'b1);
    wait_done(10, 0);
    check("t2_ir", {16'h0, ir_model}, 32'h1234);

    // 3. load to all-ones with request: fetch straddles the wrap
    min_delay = 0; max_delay = 0;
    issue(1'b1, 16'hFFFF, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_addr_lo", {16'h0, mem_address}, 32'hFFFF);
    @(negedge clk);
    check("t3_addr_hi", {16'h0, mem_address}, 32'h0000);
    wait_done(4, 2);
    check("t3_pc", {16'h0, pc_out}, 32'h0001);

    // 4. timeout
    hang = 1'b1;
    start_pc = pc_m;
    issue(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("t4_read_while_waiting", {31'h0, mem_read}, 32'h1);
    end
    @(negedge clk);
    check("t4_error", {31'h0, fetch_error}, 32'h1);
    check("t4_read_off", {30'h0, mem_read, busy}, 32'h0);
    check("t4_pc_kept", {16'h0, pc_out}, {16'h0, start_pc});
    fetch_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_req_ignored", {30'h0, busy, fetch_error}, 32'h1);
    fetch_req = 1'b0;
    hang = 1'b0;
    pc_load = 1'b1;
    pc_load_value = 16'h0100;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    @(negedge clk);
    check("t4_recover", {14'h0, fetch_error, busy, pc_out}, 32'h0000_0100);
    pc_m = 16'h0100;

    // 5. PCLoad during REQ_LO ignored, then reset during REQ_HI
    min_delay = 3; max_delay = 3;
    start_pc = pc_m;
    issue(1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_value = 16'hABCD;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_read && mem_address == start_pc + 16'd1) && n < 50);
    check("t5_reached_hi", {31'h0, mem_read}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", {ir_data, ir_lh, ir_write, fetch_done, fetch_error, mem_read, busy},
          13'h0);
    check("t5_rst_pc", {16'h0, pc_out}, 32'h0);
    check("t5_hi_pending", exp_q.size(), 1);
    exp_q.delete();
    done_q.delete();
    pc_m = 16'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_write_after_rst", {31'h0, ir_write}, 32'h0);

    // 6. back-to-back zero-wait fetches with request held
    min_delay = 0; max_delay = 0;
    done_cycles.delete();
    issue(1'b0, 16'h0, 1'b1, 1'b1);
    issue(1'b0, 16'h0, 1'b1, 1'b1);
    issue(1'b0, 16'h0, 1'b0, 1'b1);
    wait_done(0, 0);
    drain();
    check("t6_done_count", done_cycles.size(), 3);
    if (done_cycles.size() == 3) begin
      check("t6_spacing_a", done_cycles[1] - done_cycles[0], 4);
      check("t6_spacing_b", done_cycles[2] - done_cycles[1], 4);
    end
    check("t6_pc", {16'h0, pc_out}, 32'h0006);

    // Random fetches with random branches and wait states
    min_delay = 0; max_delay = 3;
    for (int i = 0; i < 40; i++) begin
      issue(($urandom_range(3, 0) == 0), 16'($urandom), 1'b0, 1'b1);
    end
    wait_idle();
    drain();
    check("rand_pc", {16'h0, pc_out}, {16'h0, pc_m});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
